sifive_gpr_loader: RTL and testbench
====================================

SIFIVE_GPR_LOADER -- requirements
Module: sifive_gpr_loader

Interface
REQ-001 Parameter: NUM_REGS, 31, number of GPRs loaded (x1..x31; x0 never written).
REQ-002 Parameter: XLEN, 32, register data width.
REQ-003 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  begin a load sequence; sampled only in IDLE.
REQ-006 Port: in_valid  input  1  load-stream data valid.
REQ-007 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-008 Port: in_data  input  XLEN  value for the current register, presented in order x1 first.
REQ-009 Port: rf_wen  output  1  register-file write request.
REQ-010 Port: rf_waddr  output  5  write register index.
REQ-011 Port: rf_wdata  output  XLEN  write data.
REQ-012 Port: rf_wack  input  1  register file accepted the write this cycle.
REQ-013 Port: rf_raddr  output  5  readback register index.
REQ-014 Port: rf_rdata  input  XLEN  readback data, valid one cycle after rf_raddr.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: done  output  1  one-cycle pulse at end of sequence.
REQ-017 Port: err  output  1  sticky readback mismatch flag.
REQ-018 Port: err_addr  output  5  index of the first mismatching register.

Function
REQ-019 The block SHALL implement states IDLE, FETCH, WRITE, RD, CMP, DONE.
REQ-020 The block SHALL hold a 5-bit index idx and an XLEN data register; idx is set to 1 on leaving IDLE.
REQ-021 In IDLE, start=1 SHALL clear err and err_addr, set idx=1, and go to FETCH next cycle; start=0 SHALL leave the state unchanged.
REQ-022 in_ready SHALL be high only in FETCH; in_valid outside FETCH SHALL be ignored, including in the start cycle.
REQ-023 In FETCH, in_valid=1 SHALL capture in_data and go to WRITE; in_valid=0 SHALL stay in FETCH indefinitely.
REQ-024 In WRITE, rf_wen SHALL be 1 with rf_waddr=idx and rf_wdata=captured data, held stable until rf_wack=1; then go to RD.
REQ-025 rf_wack outside WRITE SHALL be ignored.
REQ-026 In RD, rf_raddr SHALL equal idx; go to CMP unconditionally.
REQ-027 In CMP, rf_rdata SHALL be compared to captured data; on mismatch with err=0, set err=1 and err_addr=idx; on mismatch with err=1, leave err_addr unchanged.
REQ-028 In CMP, idx=NUM_REGS SHALL go to DONE; otherwise idx increments and the state returns to FETCH.
REQ-029 DONE SHALL last exactly one cycle with done=1, then go to IDLE; err and err_addr SHALL hold until the next accepted start.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 rf_wen SHALL be 0 and rf_raddr SHALL be 0 in every state not named in REQ-024/REQ-026.
REQ-032 Minimum latency with in_valid and rf_wack tied high SHALL be 4 cycles per register; start-to-done = 4*NUM_REGS+1 cycles.

Reset
REQ-033 reset=1 SHALL, asynchronously, force IDLE, idx=0, data=0, and in_ready, rf_wen, rf_waddr, rf_wdata, rf_raddr, busy, done, err, err_addr all to 0.
REQ-034 Reset asserted mid-sequence SHALL abandon the sequence with no further write; the first cycle after deassertion is IDLE.

Verification
REQ-035 Nominal: start, in_valid and rf_wack held 1, data x_k = 0x1000_0000+k, model echoes writes -> 31 writes to addr 1..31 in order, done pulses at cycle 125 after start, err=0.
REQ-036 Backpressure: in_valid low 3 cycles before x5, rf_wack delayed 2 cycles on x7 -> in_ready high throughout the stall, rf_wen/addr/data held stable, no duplicate or skipped write.
REQ-037 Mismatch: model corrupts readback of x9 and x20 -> err=1 from CMP of x9, err_addr=9 (not 20), done still pulses after x31.
REQ-038 Restart: after REQ-037, start again with clean model -> err and err_addr cleared on accept, final err=0.
REQ-039 Mid-op reset: assert reset during WRITE of x12 -> all outputs 0 immediately, no rf_wen after deassertion until a new start.
REQ-040 Ignored inputs: start pulsed while busy and rf_wack pulsed in FETCH -> no state change, sequence completes normally.

Source files
------------

// File: rtl/sifive_gpr_loader.sv
// Loads x1..x(NUM_REGS) from a valid/ready stream into the register file.
// Each write is read back and compared; the first mismatching index is latched.
module sifive_gpr_loader #(
    parameter int NUM_REGS = 31,
    parameter int XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_wack,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [4:0]      err_addr
);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RD, CMP, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS);

    state_t          state, state_nxt;
    logic [4:0]      idx;
    logic [XLEN-1:0] data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            data     <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= 5'd1;
                        err      <= 1'b0;
                        err_addr <= '0;
                    end
                end
                FETCH: begin
                    if (in_valid) data <= in_data;
                end
                CMP: begin
                    // Only the first mismatch is recorded; later ones leave err_addr alone.
                    if (rf_rdata != data && !err) begin
                        err      <= 1'b1;
                        err_addr <= idx;
                    end
                    if (idx != LAST_IDX) idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode purely from state, so reset clears them without a clock.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rf_wen    = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_raddr  = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = WRITE;
            end
            WRITE: begin
                rf_wen   = 1'b1;
                rf_waddr = idx;
                rf_wdata = data;
                if (rf_wack) state_nxt = RD;
            end
            RD: begin
                rf_raddr  = idx;
                state_nxt = CMP;
            end
            CMP:   state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sifive_gpr_loader.sv
// Directed bench for sifive_gpr_loader: a scenario table of full load sequences
// plus hand-written reset and idle sequences, against an echoing register-file model.
module tb_sifive_gpr_loader;

    localparam int NR = 31;
    localparam int XL = 32;
    localparam logic [XL-1:0] BAD = 32'hBAD0_0000;

    logic          clock = 1'b0;
    logic          reset, start, in_valid, in_ready, rf_wen, rf_wack, busy, done, err;
    logic [XL-1:0] in_data, rf_wdata, rf_rdata;
    logic [4:0]    rf_waddr, rf_raddr, err_addr;

    always #5 clock = ~clock;

    sifive_gpr_loader #(.NUM_REGS(NR), .XLEN(XL)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wack(rf_wack),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr)
    );

    int total = 0;
    int bad   = 0;

    // Register-file model: accepts writes on wen&wack, registered readback,
    // optional corruption of selected indices.
    logic [XL-1:0] mem [0:31];
    logic [31:0]   corrupt = '0;
    int            wcount = 0;
    logic [4:0]    wa_log [0:511];
    logic [XL-1:0] wd_log [0:511];

    always @(posedge clock) begin
        if (rf_wen && rf_wack) begin
            mem[rf_waddr]  <= rf_wdata;
            wa_log[wcount] <= rf_waddr;
            wd_log[wcount] <= rf_wdata;
            wcount         <= wcount + 1;
        end
        rf_rdata <= corrupt[rf_raddr] ? (mem[rf_raddr] ^ 32'h0000_00FF) : mem[rf_raddr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          stall_reg;
        int          stall_len;
        int          wack_reg;
        int          wack_len;
        logic [31:0] corrupt;
        int          busy_start_cyc;
        int          exp_cycles;
        logic        exp_err;
        logic [4:0]  exp_err_addr;
        int          exp_err_cyc;
    } vec_t;

    vec_t tbl [0:4];

    task automatic run_vec(input vec_t v, input int id);
        int cyc, k, cur_k, stall, wdly, base, first_err, n;
        logic ok;
        corrupt = v.corrupt;
        base = wcount;
        @(negedge clock);
        start = 1'b1; in_valid = 1'b1; in_data = BAD; rf_wack = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk($sformatf("v%0d err_cleared_on_accept", id), 64'({err, err_addr}), 64'd0);
        cyc = 1; k = 1; cur_k = 0; stall = 0; wdly = 0; first_err = 0;
        while (!done && cyc < 400) begin
            start = (cyc == v.busy_start_cyc);
            if (start) chk($sformatf("v%0d busy_at_ignored_start", id), 64'(busy), 64'd1);
            if (err && first_err == 0) first_err = cyc;
            rf_wack = 1'b1;
            if (in_ready) begin
                if (k == v.stall_reg && stall < v.stall_len) begin
                    in_valid = 1'b0; stall++;
                end else begin
                    in_valid = 1'b1; in_data = 32'h1000_0000 + XL'(k); cur_k = k; k++;
                end
            end else begin
                in_valid = 1'b1; in_data = BAD;
                if (rf_wen && cur_k == v.wack_reg) begin
                    chk($sformatf("v%0d write_held_stable", id), 64'({rf_waddr, rf_wdata}),
                        64'({5'(cur_k), 32'h1000_0000 + XL'(cur_k)}));
                    if (wdly < v.wack_len) begin rf_wack = 1'b0; wdly++; end
                end
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("v%0d start_to_done_cycles", id), 64'(cyc), 64'(v.exp_cycles));
        chk($sformatf("v%0d busy_in_done", id), 64'(busy), 64'd1);
        chk($sformatf("v%0d err", id), 64'(err), 64'(v.exp_err));
        chk($sformatf("v%0d err_addr", id), 64'(err_addr), 64'(v.exp_err_addr));
        chk($sformatf("v%0d first_err_cycle", id), 64'(first_err), 64'(v.exp_err_cyc));
        n = wcount - base;
        ok = (n == NR);
        for (int i = 0; i < NR && ok; i++) begin
            if (wa_log[base+i] != 5'(i+1) || wd_log[base+i] != 32'h1000_0000 + XL'(i+1)) ok = 1'b0;
        end
        chk($sformatf("v%0d write_seq_ok(count=%0d)", id, n), 64'(ok), 64'd1);
        @(negedge clock);
        chk($sformatf("v%0d idle_after_done", id), 64'({busy, done}), 64'd0);
        chk($sformatf("v%0d sticky_err_after_done", id), 64'({err, err_addr}),
            64'({v.exp_err, v.exp_err_addr}));
    endtask

    initial begin
        int base, k, cyc;
        tbl[0] = '{0, 0, 0, 0, 32'h0,         0,  125, 1'b0, 5'd0, 0};
        tbl[1] = '{5, 3, 7, 2, 32'h0,         0,  130, 1'b0, 5'd0, 0};
        tbl[2] = '{0, 0, 0, 0, 32'h0010_0200, 0,  125, 1'b1, 5'd9, 37};
        tbl[3] = '{0, 0, 0, 0, 32'h0,         0,  125, 1'b0, 5'd0, 0};
        tbl[4] = '{3, 2, 0, 0, 32'h0,         50, 127, 1'b0, 5'd0, 0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rf_wack = 1'b0;
        #1;
        chk("reset_outputs", 64'({in_ready, rf_wen, rf_waddr, rf_wdata, rf_raddr, busy, done, err, err_addr}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Idle with no start: stream and ack activity must be ignored.
        base = wcount;
        in_valid = 1'b1; rf_wack = 1'b1; in_data = BAD;
        repeat (5) @(negedge clock);
        chk("idle_no_start", 64'({busy, in_ready, rf_wen}), 64'd0);
        chk("idle_no_writes", 64'(wcount - base), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

        // Mid-operation reset during the write of x12, with err already set by x3.
        corrupt = 32'h0000_0008;
        @(negedge clock);
        start = 1'b1; in_valid = 1'b1; rf_wack = 1'b1; in_data = BAD;
        @(negedge clock);
        start = 1'b0; k = 1; cyc = 0;
        while (!(rf_wen && rf_waddr == 5'd12) && cyc < 200) begin
            if (in_ready) begin in_data = 32'h1000_0000 + XL'(k); k++; end
            @(negedge clock);
            cyc++;
        end
        chk("midrst_reached_write12", 64'({rf_wen, rf_waddr}), 64'({1'b1, 5'd12}));
        chk("midrst_err_before_reset", 64'({err, err_addr}), 64'({1'b1, 5'd3}));
        base = wcount;
        reset = 1'b1;
        #1;
        chk("midrst_outputs_zero", 64'({in_ready, rf_wen, rf_waddr, rf_wdata, rf_raddr, busy, done, err, err_addr}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("midrst_no_write_after", 64'(wcount - base), 64'd0);
        chk("midrst_stays_idle", 64'({busy, rf_wen, in_ready}), 64'd0);

        run_vec(tbl[0], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
